// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN core.
// Holds the input spike generator state encoding and LFSR constants.
package snn_pkg;

    localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_LFSR_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        VALID = 2'd2
    } spike_gen_state_t;

    // One Galois step, right-shifting; the mask has bit 31 set so the
    // map is invertible and a nonzero value never reaches zero.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step enable.
// Load wins over advance; the value holds when neither is asserted.
module lfsr32
    import snn_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = DEFAULT_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] value
);

    // Reload on load, step on advance, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= RESET_VALUE;
        end else if (load) begin
            value <= seed;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/input_spike_gen.sv
// Rate-coded input stage: one rate register per input, one LFSR
// compare per input per timestep, vector handed on via valid/ready.
module input_spike_gen
    import snn_pkg::*;
#(
    parameter int          NUM_INPUTS = 9,
    parameter int          RATE_WIDTH = 32,
    parameter logic [31:0] LFSR_SEED  = DEFAULT_LFSR_SEED
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rate_wr_en,
    input  logic [$clog2(NUM_INPUTS)-1:0] rate_wr_addr,
    input  logic [RATE_WIDTH-1:0]         rate_wr_data,
    input  logic [31:0]                   sim_time,
    input  logic                          start,
    input  logic                          abort,
    output logic [NUM_INPUTS-1:0]         spikes,
    output logic                          spikes_valid,
    input  logic                          spikes_ready,
    output logic [31:0]                   timestep,
    output logic                          busy,
    output logic                          done
);

    localparam int AW = $clog2(NUM_INPUTS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_INPUTS - 1);

    spike_gen_state_t      state;
    logic [RATE_WIDTH-1:0] rate_q [NUM_INPUTS];
    logic [AW-1:0]         idx;
    logic [31:0]           sim_time_q;
    logic [31:0]           lfsr_value;
    logic                  lfsr_load;
    logic                  lfsr_adv;
    logic                  fire;

    // Seed is reloaded on every accepted start so runs are reproducible.
    assign lfsr_load = (state == IDLE) && start && !abort;
    assign lfsr_adv  = (state == GEN) && !abort;
    assign fire      = (lfsr_value <= rate_q[idx]);

    lfsr32 #(
        .RESET_VALUE(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .seed   (LFSR_SEED),
        .advance(lfsr_adv),
        .value  (lfsr_value)
    );

    // Rate register file: writable in any state, out-of-range ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                rate_q[i] <= '0;
            end
        end else if (rate_wr_en && (32'(rate_wr_addr) < NUM_INPUTS)) begin
            rate_q[rate_wr_addr] <= rate_wr_data;
        end
    end

    // Run control: evaluate one input per GEN cycle, then present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            sim_time_q   <= '0;
            spikes       <= '0;
            spikes_valid <= 1'b0;
            timestep     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state        <= IDLE;
                spikes_valid <= 1'b0;
                busy         <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (sim_time == 32'd0) begin
                                done <= 1'b1;
                            end else begin
                                sim_time_q <= sim_time;
                                timestep   <= '0;
                                idx        <= '0;
                                spikes     <= '0;
                                busy       <= 1'b1;
                                state      <= GEN;
                            end
                        end
                    end
                    GEN: begin
                        spikes[idx] <= fire;
                        idx         <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            spikes_valid <= 1'b1;
                            state        <= VALID;
                        end
                    end
                    VALID: begin
                        if (spikes_ready) begin
                            spikes_valid <= 1'b0;
                            if (timestep == sim_time_q - 32'd1) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                timestep <= timestep + 32'd1;
                                idx      <= '0;
                                spikes   <= '0;
                                state    <= GEN;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_input_spike_gen.sv
// Bench for input_spike_gen: directed steps with randomized rates and
// ready, checked against an LFSR/threshold reference model.
module tb_input_spike_gen;

    localparam int N = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rate_wr_en = 1'b0;
    logic [3:0]  rate_wr_addr = '0;
    logic [31:0] rate_wr_data = '0;
    logic [31:0] sim_time = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        spikes_ready = 1'b0;
    logic [N-1:0] spikes;
    logic        spikes_valid;
    logic [31:0] timestep;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mrate [N];

    input_spike_gen dut (
        .clk         (clk),
        .rst         (rst),
        .rate_wr_en  (rate_wr_en),
        .rate_wr_addr(rate_wr_addr),
        .rate_wr_data(rate_wr_data),
        .sim_time    (sim_time),
        .start       (start),
        .abort       (abort),
        .spikes      (spikes),
        .spikes_valid(spikes_valid),
        .spikes_ready(spikes_ready),
        .timestep    (timestep),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // x^32+x^22+x^2+x+1, right-shifting Galois form
    function automatic logic [31:0] ref_next(input logic [31:0] v);
        logic [31:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 32'h8020_0003;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        rate_wr_en   = 1'b1;
        rate_wr_addr = a;
        rate_wr_data = d;
        @(negedge clk);
        rate_wr_en = 1'b0;
        if (int'(a) < N) mrate[a] = d;
    endtask

    // Expected vectors for a whole run, from the rates and the seed
    task automatic run(input string tag, input int t, input int mode,
                       input bit inj);
        logic [31:0]  l;
        logic [N-1:0] ev;
        logic [N-1:0] hold_s;
        logic [31:0]  hold_t;
        int hs, dn, cyc, stall;
        l = 32'h1;
        hs = 0; dn = 0; cyc = 0; stall = 0;
        hold_s = '0; hold_t = '0;
        @(negedge clk);
        sim_time     = t;
        start        = 1'b1;
        spikes_ready = (mode != 2);
        @(negedge clk);
        start    = 1'b0;
        sim_time = $urandom;
        while (cyc < 40 * (t + 1) + 60) begin
            if (done) begin
                dn++;
                break;
            end
            start = (inj && cyc == 4);
            if (mode == 1) spikes_ready = 1'($urandom_range(0, 1));
            if (mode == 2 && spikes_valid && stall < 20) begin
                if (stall == 0) begin
                    hold_s = spikes;
                    hold_t = timestep;
                end else begin
                    chk({tag, " hold spikes"}, 32'(spikes), 32'(hold_s));
                    chk({tag, " hold ts"}, timestep, hold_t);
                end
                stall++;
                spikes_ready = (stall == 20);
            end
            if (spikes_valid && spikes_ready) begin
                ev = '0;
                for (int i = 0; i < N; i++) begin
                    ev[i] = (l <= mrate[i]);
                    l = ref_next(l);
                end
                chk({tag, " spikes"}, 32'(spikes), 32'(ev));
                chk({tag, " timestep"}, timestep, hs);
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, " handshakes"}, hs, t);
        chk({tag, " done"}, dn, 1);
        chk({tag, " end valid"}, 32'(spikes_valid), 0);
        chk({tag, " end busy"}, 32'(busy), 0);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done), 0);
    endtask

    initial begin
        int n;
        int dseen;
        logic [N-1:0] ev;
        logic [31:0]  l;
        for (int i = 0; i < N; i++) mrate[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst spikes", 32'(spikes), 0);
        chk("rst valid", 32'(spikes_valid), 0);
        chk("rst timestep", timestep, 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        rst = 1'b0;

        run("zero", 10, 0, 0);

        for (int i = 0; i < N; i++) wr(4'(i), 32'hFFFF_FFFF);
        @(negedge clk);
        sim_time     = 1;
        start        = 1'b1;
        spikes_ready = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end while (!spikes_valid && n < 40);
        chk("latency", n, 10);
        chk("latency spikes", 32'(spikes), 32'h1FF);
        @(negedge clk);
        spikes_ready = 1'b1;
        @(negedge clk);
        chk("latency done", 32'(done), 1);
        run("ones", 3, 0, 0);

        wr(4'd0, 32'h1);
        for (int i = 1; i < N; i++) wr(4'(i), 32'h0);
        run("r0_1", 5, 0, 0);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: wr(4'(i), 32'h0);
                    1: wr(4'(i), 32'hFFFF_FFFF);
                    default: wr(4'(i), $urandom);
                endcase
            end
            wr(4'($urandom_range(9, 15)), $urandom);
            run("rand", $urandom_range(2, 6), 1, 0);
        end

        run("stall", 2, 2, 0);
        run("zero_t", 0, 0, 0);
        run("inj", 3, 0, 1);

        @(negedge clk);
        sim_time     = 4;
        start        = 1'b1;
        spikes_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort pre busy", 32'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 32'(busy), 0);
        chk("abort valid", 32'(spikes_valid), 0);
        chk("abort done", 32'(done), 0);
        dseen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || spikes_valid) dseen++;
        end
        chk("abort quiet", dseen, 0);
        run("rerun", 4, 0, 0);

        for (int i = 0; i < N; i++) wr(4'(i), 32'hFFFF_FFFF);
        @(negedge clk);
        sim_time = 3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre rst spikes", 32'(spikes), 32'h01F);
        #2;
        rst = 1'b1;
        #1;
        chk("arst spikes", 32'(spikes), 0);
        chk("arst valid", 32'(spikes_valid), 0);
        chk("arst timestep", timestep, 0);
        chk("arst busy", 32'(busy), 0);
        chk("arst done", 32'(done), 0);
        for (int i = 0; i < N; i++) mrate[i] = '0;
        @(negedge clk);
        rst = 1'b0;
        run("post_rst", 2, 0, 0);

        l  = 32'h1;
        ev = '0;
        for (int i = 0; i < N; i++) begin
            ev[i] = (l <= mrate[i]);
            l = ref_next(l);
        end
        chk("post_rst model", 32'(ev), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_spike_gen.md
Name: input_spike_gen

Overview:
- Rate-coded input stage that sits directly upstream of the SNN layer pipeline inside snn_core_top.
- Holds one 32-bit firing-rate register per network input; these are the registers written through AXI at 0x100+i.
- Once per simulation timestep it compares a pseudo-random LFSR value against each rate to build a NUM_INPUTS-wide spike vector.
- It hands that vector to the first layer over a valid/ready handshake, for sim_time timesteps per run.

Parameters:
- NUM_INPUTS, 9, number of input channels / rate registers.
- RATE_WIDTH, 32, width of each rate register and of the LFSR.
- LFSR_SEED, 32'h0000_0001, LFSR value loaded on reset and on start; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rate_wr_en  in  1  write strobe for a rate register.
- rate_wr_addr  in  $clog2(NUM_INPUTS)  rate register index.
- rate_wr_data  in  RATE_WIDTH  rate value.
- sim_time  in  32  number of timesteps to run; sampled on start.
- start  in  1  single-cycle pulse that begins a run; honoured only in IDLE.
- abort  in  1  returns the FSM to IDLE from any state.
- spikes  out  NUM_INPUTS  spike vector for the current timestep.
- spikes_valid  out  1  spikes holds a completed timestep.
- spikes_ready  in  1  downstream layer accepts spikes.
- timestep  out  32  index of the timestep being generated or presented.
- busy  out  1  a run is in progress.
- done  out  1  single-cycle pulse when a run completes.

Behaviour:
- Reset (asynchronous, active-high):
  - All rate registers = 0; LFSR = LFSR_SEED; state = IDLE.
  - spikes = 0, spikes_valid = 0, timestep = 0, busy = 0, done = 0.
- LFSR: 32-bit Galois, taps 32,22,2,1 (mask 32'h8020_0003). It advances exactly one step per GEN cycle and holds otherwise. Reloads LFSR_SEED on an accepted start, so every run is reproducible.
- Spike rule: spike[i] = (lfsr_value <= rate[i]), unsigned compare. The LFSR never holds 0, so rate 0 never fires and rate 32'hFFFF_FFFF always fires.
- Rate writes:
  - Accepted in every state; take effect from the next cycle.
  - Index ≥ NUM_INPUTS is ignored.
  - A write to index i during GEN affects the current timestep only if the write lands before index i is evaluated.
- States:
  - IDLE: start=1 with sim_time=0 → done=1 next cycle, stay IDLE. start=1 with sim_time>0 → latch sim_time, timestep=0, idx=0, clear spikes, go to GEN.
  - GEN: one input per cycle. spikes[idx] ← compare result, LFSR advances, idx++. After idx = NUM_INPUTS-1 go to VALID.
  - VALID: spikes_valid=1; spikes and timestep held stable until spikes_ready=1.
    - On handshake, if timestep == latched_sim_time-1: done=1, go to IDLE, spikes_valid=0.
    - Otherwise timestep++, idx=0, clear spikes, go to GEN.
- Latency:
  - spikes_valid rises NUM_INPUTS+1 cycles after the cycle in which start is sampled.
  - Each later timestep follows NUM_INPUTS+1 cycles after the prior handshake.
  - Ready held high gives a throughput of 1 timestep per NUM_INPUTS+1 cycles.
- busy = 1 in GEN and VALID.
- done is a 1-cycle pulse, coincident with the return to IDLE.
- start outside IDLE is ignored.
- abort has priority over every transition: next cycle state=IDLE, spikes_valid=0, no done pulse. Rate registers are preserved.
- sim_time changes during a run have no effect; only the latched copy is used.
- The timestep counter wraps at 2^32 without special handling.

Decomposition:
- Shared package snn_pkg holds:
  - LFSR_TAPS constant.
  - spike_gen_state_t enum (IDLE, GEN, VALID).
  - DEFAULT_LFSR_SEED.
- Sub-module lfsr32: ports clk, rst, load, seed, advance, value.
- Rate register file and FSM stay in input_spike_gen.

Test Plan:
- All rates 0, sim_time=10, spikes_ready tied 1 → 10 handshakes, spikes=0 every step, done pulses once, then busy=0.
- All rates 32'hFFFF_FFFF, sim_time=3 → spikes=9'h1FF on 3 handshakes; first spikes_valid 10 cycles after start; done on the 3rd handshake.
- rate[0]=32'h0000_0001, others 0, seed 1 → spike[0]=1 at timestep 0 (LFSR=1 at idx 0), 0 at subsequent steps as long as the LFSR value exceeds 1; compare against a reference-model LFSR.
- Backpressure: ready held 0 for 20 cycles in VALID → spikes, timestep and spikes_valid stable, LFSR unchanged; after ready=1 the next step resumes correctly.
- sim_time=0 with start → done=1 the next cycle, spikes_valid never asserted. start while busy → ignored, run count unchanged.
- Mid-run cases:
  - abort in GEN → IDLE next cycle, no done; a fresh start reproduces the identical spike sequence.
  - rst asserted mid-run → all outputs 0 asynchronously; rate registers read as 0 (all-zero spikes on the next run).
